// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the instruction/data RAM port arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    INSTR = 2'd1,
    DATA  = 2'd2
  } owner_e;

  localparam int RAM_LAT = 1;

endpackage

// File: rtl/ram_arb_grant.sv
// Fixed data-priority grant with a bounded fetch wait, plus the data-streak counter.
module ram_arb_grant
  import ram_arb_pkg::*;
#(
  parameter int STREAK_MAX = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   instr_req,
  input  logic   data_req,
  output logic   instr_gnt,
  output logic   data_gnt,
  output owner_e winner
);

  localparam int SW = $clog2(STREAK_MAX + 1);

  if (STREAK_MAX < 1) begin : g_bad_streak
    $error("STREAK_MAX must be at least 1");
  end

  logic          w_ireq;
  logic          w_dreq;
  logic          w_at_max;
  logic [SW-1:0] r_streak;
  logic [SW-1:0] w_streak_nxt;

  // Reset suppresses all grants even while requests are held high.
  assign w_ireq   = instr_req & ~rst;
  assign w_dreq   = data_req & ~rst;
  assign w_at_max = (r_streak == SW'(STREAK_MAX));

  always_comb begin
    instr_gnt    = 1'b0;
    data_gnt     = 1'b0;
    winner       = NONE;
    w_streak_nxt = '0;
    if (w_dreq && (!w_ireq || !w_at_max)) begin
      data_gnt = 1'b1;
      winner   = DATA;
    end else if (w_ireq) begin
      instr_gnt = 1'b1;
      winner    = INSTR;
    end
    // Streak only grows while fetch is actually being passed over.
    if (data_gnt && w_ireq && !w_at_max) begin
      w_streak_nxt = r_streak + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_streak <= '0;
    end else begin
      r_streak <= w_streak_nxt;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one read-first, byte-writable RAM between the fetch and data ports;
// drives the RAM from the winner and returns the registered read data to its owner.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_req,
  input  logic [ADDR_WIDTH-1:0]   instr_addr,
  output logic                    instr_gnt,
  output logic                    instr_rvalid,
  output logic [DATA_WIDTH-1:0]   instr_rdata,
  input  logic                    data_req,
  input  logic                    data_we,
  input  logic [DATA_WIDTH/8-1:0] data_be,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  output logic                    data_gnt,
  output logic                    data_rvalid,
  output logic [DATA_WIDTH-1:0]   data_rdata,
  output logic [DATA_WIDTH/8-1:0] ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_di,
  input  logic [DATA_WIDTH-1:0]   ram_dout
);

  if (RAM_LAT != 1) begin : g_bad_lat
    $error("owner tracking assumes a single-cycle RAM read");
  end

  logic                  w_igt;
  logic                  w_dgt;
  owner_e                w_winner;
  owner_e                r_owner_p1;
  logic                  r_last_we_p1;
  logic [ADDR_WIDTH-1:0] r_ram_addr_p1;

  ram_arb_grant #(
    .STREAK_MAX(STREAK_MAX)
  ) u_grant (
    .clk      (clk),
    .rst      (rst),
    .instr_req(instr_req),
    .data_req (data_req),
    .instr_gnt(w_igt),
    .data_gnt (w_dgt),
    .winner   (w_winner)
  );

  assign instr_gnt = w_igt;
  assign data_gnt  = w_dgt;

  // Stage p0: RAM request from the winner; idle cycles hold the last address.
  always_comb begin
    ram_we   = '0;
    ram_addr = r_ram_addr_p1;
    ram_di   = '0;
    if (w_dgt) begin
      ram_addr = data_addr;
      ram_di   = data_wdata;
      if (data_we) begin
        ram_we = data_be;
      end
    end else if (w_igt) begin
      ram_addr = instr_addr;
      ram_di   = data_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_p1    <= NONE;
      r_last_we_p1  <= 1'b0;
      r_ram_addr_p1 <= '0;
    end else begin
      r_owner_p1    <= w_winner;
      r_last_we_p1  <= w_dgt & data_we;
      r_ram_addr_p1 <= ram_addr;
    end
  end

  // Stage p1: response to the owner; reset masks a response still in flight.
  always_comb begin
    instr_rvalid = 1'b0;
    instr_rdata  = '0;
    data_rvalid  = 1'b0;
    data_rdata   = '0;
    if (!rst && r_owner_p1 == INSTR) begin
      instr_rvalid = 1'b1;
      instr_rdata  = ram_dout;
    end
    if (!rst && r_owner_p1 == DATA) begin
      data_rvalid = 1'b1;
      if (!r_last_we_p1) begin
        data_rdata = ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed table-driven bench for ram_port_arbiter with a behavioural read-first RAM.
module tb_ram_port_arbiter;

  logic        clk;
  logic        rst;
  logic        instr_req;
  logic [13:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [13:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic [3:0]  ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_di;
  logic [31:0] ram_dout;

  logic [31:0] mem [0:4095];

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic        rst;
    logic        ireq;
    logic [13:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dbe;
    logic [13:0] daddr;
    logic [31:0] dwd;
    logic        igt;
    logic        dgt;
    logic [3:0]  we;
    logic [13:0] ra;
    logic        irv;
    logic [31:0] ird;
    logic        drv;
    logic [31:0] drd;
  } vec_t;

  vec_t tbl [17];

  ram_port_arbiter #(
    .ADDR_WIDTH(14),
    .DATA_WIDTH(32),
    .STREAK_MAX(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_req   (instr_req),
    .instr_addr  (instr_addr),
    .instr_gnt   (instr_gnt),
    .instr_rvalid(instr_rvalid),
    .instr_rdata (instr_rdata),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_be     (data_be),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_gnt    (data_gnt),
    .data_rvalid (data_rvalid),
    .data_rdata  (data_rdata),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_di      (ram_di),
    .ram_dout    (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first RAM with a registered read port and byte-lane writes.
  initial begin
    for (int k = 0; k < 4096; k++) mem[k] = 32'h0;
    mem[12'h000] = 32'h01234567;
    mem[12'h002] = 32'hAABBCCDD;
    mem[12'h003] = 32'h55AA55AA;
    mem[12'h010] = 32'hDEADBEEF;
    mem[12'h020] = 32'hCAFEF00D;
    mem[12'h021] = 32'h13579BDF;
    forever begin
      @(posedge clk);
      ram_dout <= mem[ram_addr[13:2]];
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) mem[ram_addr[13:2]][b*8 +: 8] = ram_di[b*8 +: 8];
      end
    end
  end

  function automatic vec_t mk(
    input logic rs, input logic ir, input logic [13:0] ia,
    input logic dr, input logic dw, input logic [3:0] be, input logic [13:0] da,
    input logic [31:0] wd, input logic ig, input logic dg, input logic [3:0] we,
    input logic [13:0] ra, input logic iv, input logic [31:0] id,
    input logic dv, input logic [31:0] dd);
    vec_t v;
    v.rst = rs; v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwe = dw; v.dbe = be;
    v.daddr = da; v.dwd = wd; v.igt = ig; v.dgt = dg; v.we = we; v.ra = ra;
    v.irv = iv; v.ird = id; v.drv = dv; v.drd = dd;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst; instr_req = v.ireq; instr_addr = v.iaddr;
    data_req = v.dreq; data_we = v.dwe; data_be = v.dbe;
    data_addr = v.daddr; data_wdata = v.dwd;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic prev_i, prev_d, exp_i;

    //             rst ir iaddr   dr we be    daddr   wdata          igt dgt we    ra      irv ird            drv drd
    tbl[0]  = mk(1, 1, 14'h00, 1, 0, 4'h0, 14'h0, 32'h0,        0, 0, 4'h0, 14'h00, 0, 32'h0,        0, 32'h0);
    tbl[1]  = mk(1, 1, 14'h00, 1, 0, 4'h0, 14'h0, 32'h0,        0, 0, 4'h0, 14'h00, 0, 32'h0,        0, 32'h0);
    tbl[2]  = mk(1, 1, 14'h00, 1, 1, 4'hF, 14'h0, 32'h0,        0, 0, 4'h0, 14'h00, 0, 32'h0,        0, 32'h0);
    tbl[3]  = mk(0, 1, 14'h00, 1, 0, 4'h0, 14'h0, 32'h0,        0, 1, 4'h0, 14'h00, 0, 32'h0,        0, 32'h0);
    tbl[4]  = mk(0, 0, 14'h00, 0, 0, 4'h0, 14'h0, 32'h0,        0, 0, 4'h0, 14'h00, 0, 32'h0,        1, 32'h01234567);
    tbl[5]  = mk(0, 1, 14'h40, 0, 0, 4'h0, 14'h0, 32'h0,        1, 0, 4'h0, 14'h40, 0, 32'h0,        0, 32'h0);
    tbl[6]  = mk(0, 0, 14'h00, 0, 0, 4'h0, 14'h0, 32'h0,        0, 0, 4'h0, 14'h40, 1, 32'hDEADBEEF, 0, 32'h0);
    tbl[7]  = mk(0, 0, 14'h00, 1, 1, 4'h4, 14'h8, 32'h11223344, 0, 1, 4'h4, 14'h08, 0, 32'h0,        0, 32'h0);
    tbl[8]  = mk(0, 0, 14'h00, 1, 0, 4'h0, 14'h8, 32'h0,        0, 1, 4'h0, 14'h08, 0, 32'h0,        1, 32'h0);
    tbl[9]  = mk(0, 0, 14'h00, 0, 0, 4'h0, 14'h0, 32'h0,        0, 0, 4'h0, 14'h08, 0, 32'h0,        1, 32'hAA22CCDD);
    tbl[10] = mk(0, 1, 14'h80, 0, 0, 4'h0, 14'h0, 32'h0,        1, 0, 4'h0, 14'h80, 0, 32'h0,        0, 32'h0);
    tbl[11] = mk(0, 0, 14'h00, 1, 0, 4'h0, 14'hC, 32'h0,        0, 1, 4'h0, 14'h0C, 1, 32'hCAFEF00D, 0, 32'h0);
    tbl[12] = mk(0, 1, 14'h84, 0, 0, 4'h0, 14'h0, 32'h0,        1, 0, 4'h0, 14'h84, 0, 32'h0,        1, 32'h55AA55AA);
    tbl[13] = mk(0, 0, 14'h00, 0, 0, 4'h0, 14'h0, 32'h0,        0, 0, 4'h0, 14'h84, 1, 32'h13579BDF, 0, 32'h0);
    tbl[14] = mk(0, 0, 14'h00, 1, 1, 4'h0, 14'hC, 32'hFFFFFFFF, 0, 1, 4'h0, 14'h0C, 0, 32'h0,        0, 32'h0);
    tbl[15] = mk(0, 0, 14'h00, 1, 0, 4'h0, 14'hC, 32'h0,        0, 1, 4'h0, 14'h0C, 0, 32'h0,        1, 32'h0);
    tbl[16] = mk(0, 0, 14'h00, 0, 0, 4'h0, 14'h0, 32'h0,        0, 0, 4'h0, 14'h0C, 0, 32'h0,        1, 32'h55AA55AA);

    drive(mk(1, 0, 14'h0, 0, 0, 4'h0, 14'h0, 32'h0, 0, 0, 4'h0, 14'h0, 0, 32'h0, 0, 32'h0));
    next_cycle();

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("v%0d instr_gnt", i),    32'(instr_gnt),    32'(tbl[i].igt));
      chk($sformatf("v%0d data_gnt", i),     32'(data_gnt),     32'(tbl[i].dgt));
      chk($sformatf("v%0d ram_we", i),       32'(ram_we),       32'(tbl[i].we));
      chk($sformatf("v%0d ram_addr", i),     32'(ram_addr),     32'(tbl[i].ra));
      chk($sformatf("v%0d instr_rvalid", i), 32'(instr_rvalid), 32'(tbl[i].irv));
      chk($sformatf("v%0d instr_rdata", i),  instr_rdata,       tbl[i].ird);
      chk($sformatf("v%0d data_rvalid", i),  32'(data_rvalid),  32'(tbl[i].drv));
      chk($sformatf("v%0d data_rdata", i),   data_rdata,        tbl[i].drd);
      next_cycle();
    end

    // Both ports held: expect D,D,D,D,I repeating, responses one cycle later.
    drive(mk(0, 1, 14'h80, 1, 0, 4'h0, 14'h0, 32'h0, 0, 0, 4'h0, 14'h0, 0, 32'h0, 0, 32'h0));
    prev_i = 1'b0;
    prev_d = 1'b0;
    for (int i = 0; i < 15; i++) begin
      exp_i = ((i % 5) == 4);
      @(negedge clk);
      chk($sformatf("starve%0d instr_gnt", i),    32'(instr_gnt),    32'(exp_i));
      chk($sformatf("starve%0d data_gnt", i),     32'(data_gnt),     32'(!exp_i));
      chk($sformatf("starve%0d instr_rvalid", i), 32'(instr_rvalid), 32'(prev_i));
      chk($sformatf("starve%0d data_rvalid", i),  32'(data_rvalid),  32'(prev_d));
      chk($sformatf("starve%0d instr_rdata", i),  instr_rdata, prev_i ? 32'hCAFEF00D : 32'h0);
      chk($sformatf("starve%0d data_rdata", i),   data_rdata,  prev_d ? 32'h01234567 : 32'h0);
      prev_i = exp_i;
      prev_d = !exp_i;
      next_cycle();
    end

    // Data read granted, then reset: its response must never appear.
    drive(mk(0, 0, 14'h0, 1, 0, 4'h0, 14'h0, 32'h0, 0, 0, 4'h0, 14'h0, 0, 32'h0, 0, 32'h0));
    @(negedge clk);
    chk("rstmid grant data_gnt", 32'(data_gnt), 32'd1);
    next_cycle();
    drive(mk(1, 1, 14'h40, 1, 1, 4'hF, 14'h8, 32'hFFFFFFFF, 0, 0, 4'h0, 14'h0, 0, 32'h0, 0, 32'h0));
    @(negedge clk);
    chk("rstmid data_rvalid", 32'(data_rvalid), 32'd0);
    chk("rstmid data_gnt",    32'(data_gnt),    32'd0);
    chk("rstmid instr_gnt",   32'(instr_gnt),   32'd0);
    chk("rstmid ram_we",      32'(ram_we),      32'd0);
    next_cycle();
    drive(mk(0, 0, 14'h0, 1, 0, 4'h0, 14'h8, 32'h0, 0, 0, 4'h0, 14'h0, 0, 32'h0, 0, 32'h0));
    @(negedge clk);
    chk("post-rst data_gnt",    32'(data_gnt),    32'd1);
    chk("post-rst data_rvalid", 32'(data_rvalid), 32'd0);
    next_cycle();
    drive(mk(0, 0, 14'h0, 0, 0, 4'h0, 14'h0, 32'h0, 0, 0, 4'h0, 14'h0, 0, 32'h0, 0, 32'h0));
    @(negedge clk);
    chk("post-rst resp data_rvalid", 32'(data_rvalid), 32'd1);
    chk("post-rst resp data_rdata",  data_rdata,       32'hAA22CCDD);
    chk("post-rst resp instr_rvalid", 32'(instr_rvalid), 32'd0);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the single-port, byte-write-enabled, read-first RAM (1-cycle registered read) between the core's instruction-fetch port and data port. Grants at most one access per cycle, drives the RAM address/write strobes combinationally from the granted requester, and routes the registered read data back to the owner one cycle later. Sits between the rvj1 core's memory ports and the RAM in the testbench/SoC memory subsystem. Fixed data priority with a starvation bound for fetch.

## Interface
- `ADDR_WIDTH`, 14: byte-address width; the RAM word index is `addr >> 2`.
- `DATA_WIDTH`, 32: word width. Byte lanes = `DATA_WIDTH/8`.
- `STREAK_MAX`, 4: max consecutive data grants while fetch waits; must be ≥1.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_req`  in  1  fetch request; held until `instr_gnt`.
- `instr_addr`  in  ADDR_WIDTH  fetch byte address.
- `instr_gnt`  out  1  fetch accepted this cycle.
- `instr_rvalid`  out  1  `instr_rdata` valid.
- `instr_rdata`  out  DATA_WIDTH  fetched word.
- `data_req`  in  1  data request; held until `data_gnt`.
- `data_we`  in  1  1 = write, 0 = read.
- `data_be`  in  DATA_WIDTH/8  byte enables for writes.
- `data_addr`  in  ADDR_WIDTH  data byte address.
- `data_wdata`  in  DATA_WIDTH  write data.
- `data_gnt`  out  1  data access accepted this cycle.
- `data_rvalid`  out  1  response for the accepted access; read data or write ack.
- `data_rdata`  out  DATA_WIDTH  read data; 0 on write ack.
- `ram_we`  out  DATA_WIDTH/8  RAM byte write enables.
- `ram_addr`  out  ADDR_WIDTH  RAM byte address.
- `ram_di`  out  DATA_WIDTH  RAM write data.
- `ram_dout`  in  DATA_WIDTH  RAM registered read data.

## Operation
- Grant decision is combinational and made every cycle:
  - Only `data_req` set → grant data.
  - Only `instr_req` set → grant fetch.
  - Both set → grant data unless `streak == STREAK_MAX`, then grant fetch.
- `streak` counter:
  - Increments when data is granted while `instr_req` is pending.
  - Clears to 0 on any fetch grant, or in any cycle with `instr_req` low.
  - Saturates at `STREAK_MAX`.
- RAM drive from the granted requester:
  - `ram_addr` = winner's address.
  - `ram_we` = `data_be` on a granted data write; 0 otherwise.
  - `ram_di` = `data_wdata`.
- With no grant: `ram_we`=0, `ram_addr` holds its previous value (registered copy) to save toggling, `ram_di`=0.
- Owner register `owner ∈ {NONE, INSTR, DATA}`, written every cycle with this cycle's winner. It steers the next cycle's response:
  - `owner==INSTR` → `instr_rvalid`=1, `instr_rdata`=`ram_dout`.
  - `owner==DATA` → `data_rvalid`=1; `data_rdata` = `ram_dout` for a read, 0 for a write (registered `last_we`).
  - Non-owner rdata buses are 0.
- The RAM is read-first, so a read response is valid regardless of the access type issued in the same cycle.
- A data write with `data_be==0` is still granted and acknowledged; the RAM is not modified.
- No address-range checking: the RAM wraps on its index width.

## Timing
- Grant: same cycle as the request (0-cycle), when the port wins.
- Response: exactly 1 cycle after the grant. Throughput is 1 access/cycle total.
- A new request may be presented in the cycle of its own response, and may be granted back-to-back.
- Reset values: `owner`=NONE, `streak`=0, registered `ram_addr`=0, `last_we`=0. All `*_gnt`, `*_rvalid`, `ram_we` = 0; all rdata = 0.
- While `rst` is high, no grants are issued, and `ram_we` is forced to 0 even if requests are high.
- Reset mid-operation: an access granted in the cycle before reset asserts gets no response. The owner is cleared by reset, so no `rvalid` appears in the reset cycle.
- Simultaneous requests in consecutive cycles: fetch wait is bounded to `STREAK_MAX` cycles.

## Structure
- Package `ram_arb_pkg`:
  - `owner_e` enum (NONE, INSTR, DATA).
  - `RAM_LAT = 1` constant.
- Sub-module `ram_arb_grant`: combinational priority and starvation decision plus the `streak` counter. Inputs are both reqs; outputs are both gnts and the winner. The top level holds the owner and response registers and the RAM muxing.
- Total RTL is 150–250 lines.

## Test plan
- **Reset behaviour:** hold `rst` 3 cycles with both reqs high.
  - During reset: no gnt, `ram_we`=0, no rvalid.
  - First cycle after release: `data_gnt`.
- **Isolated fetch:** preload word 0x10 = 0xDEADBEEF; fetch addr 0x40.
  - Grant cycle N: `instr_gnt`.
  - Cycle N+1: `instr_rvalid`, `instr_rdata`=0xDEADBEEF.
- **Byte write then read:** write 0x11223344 to 0x8 with `be`=4'b0100, then read 0x8.
  - Byte 2 becomes 0x22, other bytes unchanged.
  - Write ack returns `data_rdata`=0.
- **Starvation bound:** both reqs held continuously with `STREAK_MAX`=4.
  - Grant pattern: D,D,D,D,I,D,D,D,D,I…
- **Back-to-back interleave:** alternate fetch and data reads every cycle.
  - Each rvalid goes to the correct port, one cycle after its grant.
  - No rdata leaks onto the other port.
- **Reset mid-access:** grant a data read, then assert `rst` in the next cycle.
  - No `data_rvalid`.
  - The following requests after reset are served normally.
